// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - central stall/flush controller for the 5-stage pipeline
//
// Purpose: merges stall requests from IF/ID/EX/MEM into the per-latch stall
// vector, turns a MEM-stage exception or eret into a one-cycle flush with a
// redirect PC, and tracks stall behaviour with a watchdog and a cycle counter.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stallreq_if/id/ex/mem  stall requests, higher stage wins
//   exc_valid          MEM reports an exception or eret this cycle
//   excepttype         exception code (32'h0000_000e = eret)
//   cp0_epc            return address used for eret
//   timeout_clr        clears the sticky watchdog flag
//   stall[5:0]         1 = hold latch ([0]=pc ... [5]=wb)
//   flush, new_pc      kill all latches and redirect fetch
//   stall_timeout      sticky watchdog flag
//   stall_cycles       saturating count of cycles with stall[0]=1
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int          MASK_CYCLES   = 2,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  input  logic        timeout_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  localparam logic [0:0]  ST_RUN    = 1'b0;
  localparam logic [0:0]  ST_MASK   = 1'b1;
  localparam logic [31:0] ERET_CODE = 32'h0000_000e;
  localparam logic [3:0]  MASK_LOAD = 4'(MASK_CYCLES);
  localparam logic [15:0] WD_LIMIT  = 16'(STALL_TIMEOUT);

  logic [0:0]  state;
  logic [3:0]  mask_cnt;
  logic [15:0] wd_cnt;
  logic [15:0] wd_next;
  logic [5:0]  req_vec;
  logic        take_exc;

  // Each code stops every latch up to the requesting stage and lets the next
  // one run, so that latch inserts a bubble.
  always_comb begin
    req_vec = 6'b000000;
    if (stallreq_mem)     req_vec = 6'b011111;
    else if (stallreq_ex) req_vec = 6'b001111;
    else if (stallreq_id) req_vec = 6'b000111;
    else if (stallreq_if) req_vec = 6'b000011;
  end

  assign take_exc = !rst && (state == ST_RUN) && exc_valid;

  // Outputs are forced to zero while reset is held, not just after the edge.
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (!rst) begin
      if (take_exc) begin
        flush  = 1'b1;
        new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
      end else begin
        stall  = req_vec;
      end
    end
  end

  // A flush always implies stall=0, so the stall[0] test also covers flush.
  always_comb begin
    wd_next = 16'h0;
    if (stall[0]) begin
      wd_next = (wd_cnt == WD_LIMIT) ? WD_LIMIT : wd_cnt + 16'h1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      mask_cnt <= 4'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_valid) begin
            state    <= ST_MASK;
            mask_cnt <= MASK_LOAD;
          end
        end
        default: begin
          mask_cnt <= mask_cnt - 4'h1;
          if (mask_cnt == 4'd1) state <= ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= 16'h0;
      stall_timeout <= 1'b0;
      stall_cycles  <= 32'h0;
    end else begin
      wd_cnt <= wd_next;
      // Set has priority over a simultaneous clear.
      if (wd_next == WD_LIMIT)  stall_timeout <= 1'b1;
      else if (timeout_clr)     stall_timeout <= 1'b0;
      if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'h1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a reference model
module tb_pipe_ctrl;

  localparam int MASK_N = 2;
  localparam int TO_N   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic        exc_valid = 1'b0;
  logic [31:0] excepttype = 32'h0;
  logic [31:0] cp0_epc = 32'h0;
  logic        timeout_clr = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .MASK_CYCLES  (MASK_N),
    .STALL_TIMEOUT(TO_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .exc_valid    (exc_valid),
    .excepttype   (excepttype),
    .cp0_epc      (cp0_epc),
    .timeout_clr  (timeout_clr),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .stall_timeout(stall_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Reference model: counts of remaining masked cycles and stalled cycles.
  int          m_mask_left;
  int          m_wd;
  bit          m_to;
  longint      m_cyc;
  logic [5:0]  m_stall;
  logic        m_flush;
  logic [31:0] m_pc;

  function automatic void model_reset();
    m_mask_left = 0;
    m_wd        = 0;
    m_to        = 1'b0;
    m_cyc       = 0;
  endfunction

  function automatic void model_eval();
    int n;
    // number of latches held = depth of the deepest requesting stage
    n = stallreq_mem ? 5 : stallreq_ex ? 4 : stallreq_id ? 3 : stallreq_if ? 2 : 0;
    m_flush = !rst && exc_valid && (m_mask_left == 0);
    m_pc    = m_flush ? ((excepttype == 32'h0000_000e) ? cp0_epc : 32'h0000_0020) : 32'h0;
    m_stall = (rst || m_flush) ? 6'b0 : 6'((1 << n) - 1);
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_flush) m_mask_left = MASK_N;
      else if (m_mask_left > 0) m_mask_left--;
      if (m_stall[0]) begin
        if (m_wd < TO_N) m_wd++;
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
      end else begin
        m_wd = 0;
      end
      if (m_wd == TO_N) m_to = 1'b1;
      else if (timeout_clr) m_to = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    exc_valid = 0; timeout_clr = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    stallreq_mem = 1;
    #3;
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_hold_stall: got %b expected %b", stall, 6'b0); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_hold_flush: got %b expected 0", flush); end
    stallreq_mem = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(negedge clk);
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall: got %b expected %b", stall, 6'b0); end
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0) begin errors++; $display("FAIL reset_flush: got %b/%h expected 0/0", flush, new_pc); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %0d expected 0", stall_cycles); end
    checks++; if (stall_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", stall_timeout); end
    tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    stallreq_id = 1; stallreq_mem = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_eval();
      checks++; if (stall !== 6'b011111 || stall !== m_stall) begin errors++; $display("FAIL prio_mem_id: got %b expected %b", stall, m_stall); end
      tick();
    end
    stallreq_mem = 0;
    @(negedge clk); model_eval();
    checks++; if (stall_cycles !== 32'd3 || stall_cycles !== m_cyc[31:0]) begin errors++; $display("FAIL prio_cycles: got %0d expected %0d", stall_cycles, m_cyc); end
    checks++; if (stall !== 6'b000111 || stall !== m_stall) begin errors++; $display("FAIL prio_drop_mem: got %b expected %b", stall, m_stall); end
    tick();
    for (int c = 0; c < 16; c++) begin
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'(c);
      @(negedge clk); model_eval();
      checks++; if (stall !== m_stall) begin errors++; $display("FAIL prio_combo_%0d: got %b expected %b", c, stall, m_stall); end
      checks++; if (stall_cycles !== m_cyc[31:0]) begin errors++; $display("FAIL prio_combo_cycles_%0d: got %0d expected %0d", c, stall_cycles, m_cyc); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_exception();
    idle_inputs();
    exc_valid = 1; excepttype = 32'h0000_0008; stallreq_ex = 1; cp0_epc = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); model_eval();
      checks++; if (flush !== ((i == 0) || (i == 3)) || flush !== m_flush) begin errors++; $display("FAIL exc_flush_%0d: got %b expected %b", i, flush, m_flush); end
      checks++; if (stall !== m_stall) begin errors++; $display("FAIL exc_stall_%0d: got %b expected %b", i, stall, m_stall); end
      checks++; if (new_pc !== m_pc) begin errors++; $display("FAIL exc_pc_%0d: got %h expected %h", i, new_pc, m_pc); end
      tick();
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_eret();
    idle_inputs();
    exc_valid = 1; excepttype = 32'h0000_000e; cp0_epc = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); model_eval();
      checks++; if (flush !== (i == 0) || flush !== m_flush) begin errors++; $display("FAIL eret_flush_%0d: got %b expected %b", i, flush, m_flush); end
      checks++; if (new_pc !== ((i == 0) ? 32'h0000_1234 : 32'h0) || new_pc !== m_pc) begin errors++; $display("FAIL eret_pc_%0d: got %h expected %h", i, new_pc, m_pc); end
      tick();
      exc_valid = 0;
    end
  endtask

  task automatic test_timeout();
    idle_inputs();
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
    stallreq_if = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (stall_timeout !== (k >= TO_N) || stall_timeout !== m_to) begin errors++; $display("FAIL timeout_rise_%0d: got %b expected %b", k, stall_timeout, m_to); end
      tick();
    end
    stallreq_if = 0; timeout_clr = 1;
    @(negedge clk);
    checks++; if (stall_timeout !== 1'b1) begin errors++; $display("FAIL timeout_held: got %b expected 1", stall_timeout); end
    tick();
    timeout_clr = 0;
    @(negedge clk);
    checks++; if (stall_timeout !== 1'b0 || stall_timeout !== m_to) begin errors++; $display("FAIL timeout_clear: got %b expected %b", stall_timeout, m_to); end
    stallreq_if = 1;
    for (int k = 0; k < TO_N; k++) begin
      timeout_clr = (k == TO_N - 1);
      tick();
    end
    @(negedge clk);
    checks++; if (stall_timeout !== 1'b1 || stall_timeout !== m_to) begin errors++; $display("FAIL timeout_set_wins: got %b expected %b", stall_timeout, m_to); end
    idle_inputs();
    timeout_clr = 1;
    tick();
    timeout_clr = 0;
  endtask

  task automatic test_reset_mid_mask();
    idle_inputs();
    stallreq_mem = 1;
    repeat (5) tick();
    // start from a known count of 5 regardless of earlier history
    rst = 1; #1; rst = 0; model_reset();
    repeat (5) tick();
    @(negedge clk);
    checks++; if (stall_cycles !== 32'd5 || stall_cycles !== m_cyc[31:0]) begin errors++; $display("FAIL mid_mask_pre_cycles: got %0d expected %0d", stall_cycles, m_cyc); end
    stallreq_mem = 0; exc_valid = 1; excepttype = 32'h0000_0008;
    tick();
    stallreq_mem = 1;
    @(negedge clk); model_eval();
    checks++; if (flush !== 1'b0 || stall !== 6'b011111 || stall !== m_stall) begin errors++; $display("FAIL mid_mask_masked: got %b/%b expected 0/%b", flush, stall, m_stall); end
    #2 rst = 1;
    #1;
    model_reset();
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL mid_mask_rst_cycles: got %0d expected 0", stall_cycles); end
    checks++; if (flush !== 1'b0 || stall !== 6'b0) begin errors++; $display("FAIL mid_mask_rst_out: got %b/%b expected 0/000000", flush, stall); end
    @(posedge clk); #1;
    rst = 0; stallreq_mem = 0;
    @(negedge clk); model_eval();
    checks++; if (flush !== 1'b1 || new_pc !== 32'h0000_0020 || flush !== m_flush) begin errors++; $display("FAIL mid_mask_post_exc: got %b/%h expected 1/00000020", flush, new_pc); end
    tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stallreq_if  = ($urandom_range(3) == 0);
      stallreq_id  = ($urandom_range(3) == 0);
      stallreq_ex  = ($urandom_range(5) == 0);
      stallreq_mem = ($urandom_range(5) == 0);
      exc_valid    = ($urandom_range(7) == 0);
      excepttype   = ($urandom_range(1) == 0) ? 32'h0000_000e : $urandom;
      cp0_epc      = $urandom;
      timeout_clr  = ($urandom_range(7) == 0);
      @(negedge clk); model_eval();
      checks++; if (stall !== m_stall) begin errors++; $display("FAIL rand_stall_%0d: got %b expected %b", i, stall, m_stall); end
      checks++; if (flush !== m_flush) begin errors++; $display("FAIL rand_flush_%0d: got %b expected %b", i, flush, m_flush); end
      checks++; if (new_pc !== m_pc) begin errors++; $display("FAIL rand_pc_%0d: got %h expected %h", i, new_pc, m_pc); end
      checks++; if (stall_timeout !== m_to) begin errors++; $display("FAIL rand_timeout_%0d: got %b expected %b", i, stall_timeout, m_to); end
      checks++; if (stall_cycles !== m_cyc[31:0]) begin errors++; $display("FAIL rand_cycles_%0d: got %0d expected %0d", i, stall_cycles, m_cyc); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_exception();
    test_eret();
    test_timeout();
    test_reset_mid_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Collects stall requests from IF, ID, EX and MEM and produces the 6-bit stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb latches.
- On an exception or eret reported by MEM, it issues a pipeline flush and the redirect PC.
- Tracks stall behaviour with a watchdog and a stall-cycle performance counter.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for all non-eret exceptions.
- MASK_CYCLES, 2, cycles after a flush during which further exc_valid is ignored (1..15).
- STALL_TIMEOUT, 1024, consecutive stall[0] cycles that raise stall_timeout (2..65535).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stallreq_if  in  1  fetch/instruction-bus not ready.
- stallreq_id  in  1  load-use or branch hazard in ID.
- stallreq_ex  in  1  multi-cycle div/madd busy.
- stallreq_mem  in  1  data bus not ready.
- exc_valid  in  1  MEM stage reports an exception or eret this cycle.
- excepttype  in  32  exception code from MEM; 32'h0000_000e means eret.
- cp0_epc  in  32  current EPC from CP0.
- timeout_clr  in  1  clears sticky stall_timeout.
- stall  out  6  [0]=pc, [1]=if_id, [2]=id_ex, [3]=ex_mem, [4]=mem_wb, [5]=wb; 1=Stop.
- flush  out  1  kill all latches this cycle.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  saturating count of cycles with stall[0]=1.

Behaviour:
- Reset (async, immediate): state=RUN, mask counter=0, watchdog=0, stall_timeout=0, stall_cycles=0. Outputs during reset: stall=0, flush=0, new_pc=0.
- stall and flush are combinational from inputs and state (0-cycle latency), so a latch sees them in the same cycle as the request.
- Stall priority (highest first):
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- Each code bubbles the first unstalled latch, as mem_wb does when stall[4]=Stop and stall[5]=NoStop.
- FSM states: RUN and MASK.
  - RUN with exc_valid=1: flush=1 and stall=6'b000000 regardless of stall requests (the exception wins). new_pc=cp0_epc if excepttype==32'h0000_000e, else EXC_VECTOR. Next state MASK; mask counter loaded with MASK_CYCLES.
  - MASK: exc_valid is ignored, flush=0 and new_pc=0, and stall follows the normal priority. The counter decrements each cycle; return to RUN on the edge where the counter reads 1.
  - RUN with exc_valid=0: flush=0, new_pc=0.
- Watchdog:
  - Increments each cycle stall[0]=1, saturating at STALL_TIMEOUT.
  - Clears to 0 on any cycle stall[0]=0 or flush=1.
  - On reaching STALL_TIMEOUT, stall_timeout is set and held. timeout_clr=1 clears it next edge; a clear and a set in the same cycle resolve to set.
- stall_cycles: +1 per cycle stall[0]=1, saturating at 32'hFFFF_FFFF, never wraps. Flush cycles do not count.
- Reset asserted mid-stall or mid-MASK: all state drops immediately. After release, the first cycle is RUN with counters at 0.

Test Plan:
- Reset release with no requests -> stall=6'b000000, flush=0, stall_cycles=0, stall_timeout=0.
- stallreq_id=1 and stallreq_mem=1 together for 3 cycles -> stall=6'b011111 each cycle, stall_cycles=3 after the third edge; then drop mem only -> stall=6'b000111 in the same cycle.
- exc_valid=1, excepttype=32'h0000_0008, stallreq_ex=1 -> flush=1, stall=0, new_pc=32'h20. Re-assert exc_valid for the next 2 cycles -> flush=0 in both (MASK). Third cycle with exc_valid=1 -> flush=1 again.
- exc_valid=1, excepttype=32'h0000_000e, cp0_epc=32'h0000_1234 -> new_pc=32'h1234, flush=1 for exactly one cycle.
- STALL_TIMEOUT=8, stallreq_if held for 10 cycles -> stall_timeout rises after the 8th stalled edge and stays 1. timeout_clr pulse with stall released -> 0.
- rst asserted asynchronously mid-MASK with stall_cycles=5 -> stall_cycles=0, flush=0, stall=0 immediately. exc_valid in the first cycle after release -> flush=1.
